full_st1_act: RTL and testbench
===============================

Name: full_st1_act

Overview:
- Activation stage directly downstream of stage 1 of the fully-connected pipeline.
- Forward path: consumes the stage_1_data_out stream, applies ReLU or leaky ReLU, and emits the stage_2_data stream.
- Records a per-element derivative mask for each vector.
- Backward path: gates the stage_2_error stream with that mask to produce the stage_1_error stream that feeds stage 1's error port.

Parameters:
- VEC_LEN, 6: elements per vector; mask depth.
- LEAKY, 0: 0 = ReLU, 1 = leaky ReLU.
- LEAK_SHIFT, 3: leaky slope is 2^-LEAK_SHIFT; range 1..7.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- err_en  in  1  training mode; 0 = inference (no mask hold, error path idle)
- stage_1_data_out  in  32  float_24_8 from stage 1
- stage_1_data_out_fst  in  1  first element of vector
- stage_1_data_out_vld  in  1  input valid
- stage_1_data_out_rdy  out  1  input ready
- stage_2_data  out  32  activated float_24_8
- stage_2_data_fst  out  1  first flag, pipelined with data
- stage_2_data_vld  out  1  output valid
- stage_2_data_rdy  in  1  downstream ready
- stage_2_error  in  32  float_24_8 error from stage 2
- stage_2_error_fst  in  1  first error element
- stage_2_error_vld  in  1  error valid
- stage_2_error_rdy  out  1  error ready
- stage_1_error  out  32  gated float_24_8 error to stage 1
- stage_1_error_fst  out  1  first flag
- stage_1_error_vld  out  1  valid
- stage_1_error_rdy  in  1  stage 1 error ready
- act_busy  out  1  high whenever state != FILL

Behaviour:
- Reset (async, active-high): all *_vld outputs 0, data outputs 0, fst outputs 0, state FILL, fwd_idx 0, err_idx 0, mask 0.
- Float format: bit 31 sign, bits 30:23 exponent, bits 22:0 mantissa. Exponent 0 is zero; denormals are flushed to zero.
- Forward activation:
  - Non-negative input (sign 0, exp != 0): passed unchanged.
  - Negative input or zero, LEAKY=0: output +0 (0x00000000).
  - Negative input, LEAKY=1: exponent decreased by LEAK_SHIFT; result is +0 if exp <= LEAK_SHIFT.
  - -0 always becomes +0.
  - No NaN/Inf special-casing; the sign bit alone decides.
- Mask bit: 1 iff sign==0 and exp!=0. Written at mask[fwd_idx] on each accepted forward beat.
- Pipelining: each path is one register stage, latency 1 cycle, full throughput.
  - Output valid is held with stable data until its rdy is asserted.
  - Forward input rdy = (!stage_2_data_vld | stage_2_data_rdy) & (state==FILL | !err_en).
  - Error input rdy = (!stage_1_error_vld | stage_1_error_rdy) & (state==HOLD).
- State machine (err_en=1):
  - FILL: an accepted beat with fst=1 forces fwd_idx to 0, then increments it. Accepting beat index VEC_LEN-1 sets fwd_idx to 0 and moves to HOLD.
  - HOLD: forward is blocked; errors are accepted. An error beat with fst=1 forces err_idx to 0.
    - Output = error if mask[err_idx]=1.
    - Otherwise output = +0 (LEAKY=0), or the error with exponent reduced by LEAK_SHIFT (LEAKY=1, same flush rule).
    - Accepting error index VEC_LEN-1 sets err_idx to 0 and returns to FILL.
- err_en=0: state stays FILL, fwd_idx still wraps at VEC_LEN, and stage_2_error_rdy=0. Clearing err_en while in HOLD returns to FILL on the next clock and discards the remaining error beats.
- Simultaneous events:
  - The last forward beat and a new error arriving in the same cycle: the error is not accepted that cycle.
  - An output handshake completing while a new beat is accepted in the same cycle: the register reloads with no bubble.
- Reset mid-vector: the partial mask is discarded and the block restarts in FILL.

Decomposition:
- Shared types package:
  - float_24_8 typedef and field-slice constants (sign bit, exponent range).
  - act_state_t enum {FILL, HOLD}.
  - Function float_scale_down(f, shift) returning a flushed float.
- One sub-module, full_st1_act_pipe: a generic 32-bit valid/ready register slice with fst and a combinational transform input. It is instantiated once for the forward path and once for the error path.
- Mask, counters and state machine stay in the top module.

Test Plan:
- ReLU, err_en=0, inputs 0x3F800000, 0xC0000000, 0x80000000, 0x40400000, stage_2_data_rdy=1 -> outputs 0x3F800000, 0x00000000, 0x00000000, 0x40400000, each 1 cycle later, with fst preserved.
- LEAKY=1, LEAK_SHIFT=2, input 0xC0000000 (-2.0) -> output 0xBF000000 (-0.5). Input 0x80800000 (exp 1) -> 0x00000000.
- ReLU, err_en=1, VEC_LEN=6, forward signs +,-,+,-,+,+ -> stage_1_data_out_rdy drops after the 6th beat. Six errors of 0x3F800000 -> outputs 1,0,1,0,1,1 (0x3F800000/0x00000000), then forward rdy returns.
- Backpressure: stage_2_data_rdy held 0 for 5 cycles with a valid pending -> stage_2_data and vld stable, input rdy=0. Release -> one beat per cycle with no loss.
- fst=1 re-asserted on forward beat 3 -> fwd_idx restarts. HOLD is entered only after 6 beats counted from the new fst.
- Assert reset while in HOLD with stage_1_error_vld=1 -> all vld 0 immediately, state FILL, forward rdy=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/full_st1_act_pkg.sv
// Shared types for the stage-1 activation block.
// Contents: float_24_8 type and field positions, act_state_t FSM encoding,
// and float_scale_down(), which multiplies a float by 2^-shift and flushes
// the result to +0 when the exponent would reach zero or wrap below it.
package full_st1_act_pkg;

    typedef logic [31:0] float_24_8;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MAN_MSB  = 22;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } act_state_t;

    function automatic float_24_8 float_scale_down(input float_24_8 f, input logic [7:0] shift);
        logic [7:0] exp_v;
        exp_v = f[EXP_MSB:EXP_LSB];
        if (exp_v <= shift) begin
            return '0;
        end
        return {f[SIGN_BIT], exp_v - shift, f[MAN_MSB:0]};
    endfunction

endpackage

// File: rtl/full_st1_act_pipe.sv
// Single valid/ready register slice carrying a 32-bit word and a first flag.
// The word is already transformed by the caller; this slice only registers it.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_en            extra accept qualifier from the owner (e.g. FSM state)
//   i_vld/i_data/i_fst, o_rdy   upstream side
//   o_acc           upstream beat accepted this cycle
//   o_vld/o_data/o_fst, i_rdy   downstream side
module full_st1_act_pipe
    import full_st1_act_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_en,
    input  logic      i_vld,
    input  float_24_8 i_data,
    input  logic      i_fst,
    output logic      o_rdy,
    output logic      o_acc,
    output float_24_8 o_data,
    output logic      o_fst,
    output logic      o_vld,
    input  logic      i_rdy
);

    float_24_8 r_data;
    logic      r_fst;
    logic      r_vld;
    logic      w_rdy;

    // Can take a new beat when empty or when the held beat leaves this cycle.
    assign w_rdy = (!r_vld || i_rdy) && i_en;
    assign o_rdy = w_rdy;
    assign o_acc = w_rdy && i_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_fst  <= 1'b0;
            r_vld  <= 1'b0;
        end else if (w_rdy && i_vld) begin
            r_data <= i_data;
            r_fst  <= i_fst;
            r_vld  <= 1'b1;
        end else if (i_rdy) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_fst  = r_fst;
    assign o_vld  = r_vld;

endmodule

// File: rtl/full_st1_act.sv
// Activation stage after FC stage 1.
// Forward: ReLU / leaky ReLU on stage_1_data_out -> stage_2_data, recording a
// derivative mask per vector element. Backward (err_en=1): stage_2_error is
// gated by that mask and emitted on stage_1_error.
// Ports: clk/reset; err_en training mode; stage_1_data_out* input stream;
// stage_2_data* activated stream; stage_2_error* error in; stage_1_error*
// gated error out; act_busy high while in HOLD.
module full_st1_act
    import full_st1_act_pkg::*;
#(
    parameter int unsigned VEC_LEN    = 6,
    parameter int unsigned LEAKY      = 0,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      err_en,
    input  float_24_8 stage_1_data_out,
    input  logic      stage_1_data_out_fst,
    input  logic      stage_1_data_out_vld,
    output logic      stage_1_data_out_rdy,
    output float_24_8 stage_2_data,
    output logic      stage_2_data_fst,
    output logic      stage_2_data_vld,
    input  logic      stage_2_data_rdy,
    input  float_24_8 stage_2_error,
    input  logic      stage_2_error_fst,
    input  logic      stage_2_error_vld,
    output logic      stage_2_error_rdy,
    output float_24_8 stage_1_error,
    output logic      stage_1_error_fst,
    output logic      stage_1_error_vld,
    input  logic      stage_1_error_rdy,
    output logic      act_busy
);

    localparam int unsigned   IW       = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(VEC_LEN - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [7:0]    SHIFT8   = 8'(LEAK_SHIFT);

    act_state_t           r_state, w_state_nxt;
    logic [IW-1:0]        r_fwd_idx, w_fwd_idx_nxt, w_fwd_idx;
    logic [IW-1:0]        r_err_idx, w_err_idx_nxt, w_err_idx;
    logic [VEC_LEN-1:0]   r_mask;

    logic      w_fwd_en, w_err_en;
    logic      w_fwd_acc, w_err_acc;
    logic      w_pos;
    float_24_8 w_fwd_data, w_err_data;

    assign w_fwd_en = (r_state == FILL) || !err_en;
    assign w_err_en = (r_state == HOLD) && err_en;

    // fst restarts the element count on either path.
    assign w_fwd_idx = stage_1_data_out_fst ? '0 : r_fwd_idx;
    assign w_err_idx = stage_2_error_fst ? '0 : r_err_idx;

    always_comb begin
        w_pos      = !stage_1_data_out[SIGN_BIT] && (stage_1_data_out[EXP_MSB:EXP_LSB] != 8'd0);
        w_fwd_data = '0;
        if (w_pos) begin
            w_fwd_data = stage_1_data_out;
        end else if ((LEAKY != 0) && stage_1_data_out[SIGN_BIT]) begin
            // -0 has exponent 0 and therefore flushes to +0 here as well.
            w_fwd_data = float_scale_down(stage_1_data_out, SHIFT8);
        end
    end

    always_comb begin
        w_err_data = '0;
        if (r_mask[w_err_idx]) begin
            w_err_data = stage_2_error;
        end else if (LEAKY != 0) begin
            w_err_data = float_scale_down(stage_2_error, SHIFT8);
        end
    end

    full_st1_act_pipe u_fwd (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_fwd_en),
        .i_vld  (stage_1_data_out_vld),
        .i_data (w_fwd_data),
        .i_fst  (stage_1_data_out_fst),
        .o_rdy  (stage_1_data_out_rdy),
        .o_acc  (w_fwd_acc),
        .o_data (stage_2_data),
        .o_fst  (stage_2_data_fst),
        .o_vld  (stage_2_data_vld),
        .i_rdy  (stage_2_data_rdy)
    );

    full_st1_act_pipe u_err (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_err_en),
        .i_vld  (stage_2_error_vld),
        .i_data (w_err_data),
        .i_fst  (stage_2_error_fst),
        .o_rdy  (stage_2_error_rdy),
        .o_acc  (w_err_acc),
        .o_data (stage_1_error),
        .o_fst  (stage_1_error_fst),
        .o_vld  (stage_1_error_vld),
        .i_rdy  (stage_1_error_rdy)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_fwd_idx_nxt = r_fwd_idx;
        w_err_idx_nxt = r_err_idx;

        if (w_fwd_acc) begin
            w_fwd_idx_nxt = (w_fwd_idx == LAST_IDX) ? '0 : w_fwd_idx + IDX_ONE;
            if ((w_fwd_idx == LAST_IDX) && err_en && (r_state == FILL)) begin
                w_state_nxt = HOLD;
            end
        end

        if (r_state == HOLD) begin
            if (!err_en) begin
                // Leaving training mode abandons the rest of the error vector.
                w_state_nxt   = FILL;
                w_err_idx_nxt = '0;
            end else if (w_err_acc) begin
                w_err_idx_nxt = (w_err_idx == LAST_IDX) ? '0 : w_err_idx + IDX_ONE;
                if (w_err_idx == LAST_IDX) begin
                    w_state_nxt = FILL;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= FILL;
            r_fwd_idx <= '0;
            r_err_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_fwd_idx <= w_fwd_idx_nxt;
            r_err_idx <= w_err_idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_fwd_acc) begin
            r_mask[w_fwd_idx] <= w_pos;
        end
    end

    assign act_busy = (r_state != FILL);

endmodule

// File: tb/tb_full_st1_act.sv
module tb_full_st1_act;
    import full_st1_act_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ReLU instance (defaults)
    logic      err_en = 1'b0;
    float_24_8 d_in = '0;
    logic      d_fst = 1'b0, d_vld = 1'b0, d_rdy;
    float_24_8 q;
    logic      q_fst, q_vld, q_rdy = 1'b1;
    float_24_8 e_in = '0;
    logic      e_fst = 1'b0, e_vld = 1'b0, e_rdy;
    float_24_8 eo;
    logic      eo_fst, eo_vld, eo_rdy = 1'b1;
    logic      busy;

    // Leaky instance, LEAK_SHIFT = 2
    logic      l_err_en = 1'b0;
    float_24_8 l_d_in = '0;
    logic      l_d_fst = 1'b0, l_d_vld = 1'b0, l_d_rdy;
    float_24_8 l_q;
    logic      l_q_fst, l_q_vld, l_q_rdy = 1'b1;
    float_24_8 l_e_in = '0;
    logic      l_e_fst = 1'b0, l_e_vld = 1'b0, l_e_rdy;
    float_24_8 l_eo;
    logic      l_eo_fst, l_eo_vld, l_eo_rdy = 1'b1;
    logic      l_busy;

    full_st1_act #(.VEC_LEN(6), .LEAKY(0), .LEAK_SHIFT(3)) u_relu (
        .clk                  (clk),
        .reset                (reset),
        .err_en               (err_en),
        .stage_1_data_out     (d_in),
        .stage_1_data_out_fst (d_fst),
        .stage_1_data_out_vld (d_vld),
        .stage_1_data_out_rdy (d_rdy),
        .stage_2_data         (q),
        .stage_2_data_fst     (q_fst),
        .stage_2_data_vld     (q_vld),
        .stage_2_data_rdy     (q_rdy),
        .stage_2_error        (e_in),
        .stage_2_error_fst    (e_fst),
        .stage_2_error_vld    (e_vld),
        .stage_2_error_rdy    (e_rdy),
        .stage_1_error        (eo),
        .stage_1_error_fst    (eo_fst),
        .stage_1_error_vld    (eo_vld),
        .stage_1_error_rdy    (eo_rdy),
        .act_busy             (busy)
    );

    full_st1_act #(.VEC_LEN(6), .LEAKY(1), .LEAK_SHIFT(2)) u_leaky (
        .clk                  (clk),
        .reset                (reset),
        .err_en               (l_err_en),
        .stage_1_data_out     (l_d_in),
        .stage_1_data_out_fst (l_d_fst),
        .stage_1_data_out_vld (l_d_vld),
        .stage_1_data_out_rdy (l_d_rdy),
        .stage_2_data         (l_q),
        .stage_2_data_fst     (l_q_fst),
        .stage_2_data_vld     (l_q_vld),
        .stage_2_data_rdy     (l_q_rdy),
        .stage_2_error        (l_e_in),
        .stage_2_error_fst    (l_e_fst),
        .stage_2_error_vld    (l_e_vld),
        .stage_2_error_rdy    (l_e_rdy),
        .stage_1_error        (l_eo),
        .stage_1_error_fst    (l_eo_fst),
        .stage_1_error_vld    (l_eo_vld),
        .stage_1_error_rdy    (l_eo_rdy),
        .act_busy             (l_busy)
    );

    task automatic test_reset();
        #3;
        checks++;
        if (q_vld !== 1'b0 || eo_vld !== 1'b0 || l_q_vld !== 1'b0 || l_eo_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld: got %b%b%b%b want 0000", q_vld, eo_vld, l_q_vld, l_eo_vld);
        end
        checks++;
        if (q !== 32'h0 || eo !== 32'h0 || q_fst !== 1'b0 || eo_fst !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got q=%h eo=%h fst=%b%b want 0", q, eo, q_fst, eo_fst);
        end
        checks++;
        if (busy !== 1'b0 || d_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got busy=%b rdy=%b want busy=0 rdy=1", busy, d_rdy);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_relu_stream();
        logic [31:0] vin [4];
        logic [31:0] vexp [4];
        vin  = '{32'h3F800000, 32'hC0000000, 32'h80000000, 32'h40400000};
        vexp = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h40400000};
        err_en = 1'b0;
        q_rdy  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            d_in  = vin[i];
            d_fst = (i == 0);
            d_vld = 1'b1;
            @(negedge clk);
            checks++;
            if (q !== vexp[i] || q_vld !== 1'b1 || q_fst !== (i == 0)) begin
                errors++;
                $display("FAIL relu_beat%0d: got %h vld=%b fst=%b want %h vld=1 fst=%b",
                         i, q, q_vld, q_fst, vexp[i], (i == 0));
            end
        end
        d_vld = 1'b0;
        d_fst = 1'b0;
        @(negedge clk);
        checks++;
        if (q_vld !== 1'b0) begin
            errors++;
            $display("FAIL relu_drain: got vld=%b want 0", q_vld);
        end
    endtask

    task automatic test_leaky();
        l_err_en = 1'b0;
        l_q_rdy  = 1'b1;
        @(negedge clk);
        l_d_in  = 32'hC0000000;
        l_d_fst = 1'b1;
        l_d_vld = 1'b1;
        @(negedge clk);
        checks++;
        if (l_q !== 32'hBF000000 || l_q_vld !== 1'b1) begin
            errors++;
            $display("FAIL leaky_neg: got %h vld=%b want bf000000 vld=1", l_q, l_q_vld);
        end
        l_d_in  = 32'h80800000;
        l_d_fst = 1'b0;
        @(negedge clk);
        checks++;
        if (l_q !== 32'h00000000 || l_q_vld !== 1'b1) begin
            errors++;
            $display("FAIL leaky_flush: got %h vld=%b want 00000000 vld=1", l_q, l_q_vld);
        end
        l_d_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_leaky_error();
        l_err_en = 1'b1;
        l_eo_rdy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            l_d_in  = (i == 0) ? 32'h3F800000 : 32'hC0000000;
            l_d_fst = (i == 0);
            l_d_vld = 1'b1;
            @(negedge clk);
        end
        l_d_vld = 1'b0;
        l_d_fst = 1'b0;
        checks++;
        if (l_busy !== 1'b1) begin
            errors++;
            $display("FAIL leaky_hold: got busy=%b want 1", l_busy);
        end
        l_e_in  = 32'h40000000;
        l_e_fst = 1'b1;
        l_e_vld = 1'b1;
        @(negedge clk);
        checks++;
        if (l_eo !== 32'h40000000 || l_eo_vld !== 1'b1) begin
            errors++;
            $display("FAIL leaky_err_pass: got %h vld=%b want 40000000 vld=1", l_eo, l_eo_vld);
        end
        l_e_fst = 1'b0;
        @(negedge clk);
        checks++;
        if (l_eo !== 32'h3F000000 || l_eo_vld !== 1'b1) begin
            errors++;
            $display("FAIL leaky_err_scaled: got %h vld=%b want 3f000000 vld=1", l_eo, l_eo_vld);
        end
        l_e_vld  = 1'b0;
        l_err_en = 1'b0;
        @(negedge clk);
        checks++;
        if (l_busy !== 1'b0) begin
            errors++;
            $display("FAIL leaky_exit: got busy=%b want 0", l_busy);
        end
    endtask

    task automatic test_backpressure();
        err_en = 1'b0;
        @(negedge clk);
        q_rdy = 1'b0;
        d_in  = 32'h11000000;
        d_fst = 1'b1;
        d_vld = 1'b1;
        @(negedge clk);
        d_in  = 32'h12000000;
        d_fst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (q !== 32'h11000000 || q_vld !== 1'b1 || q_fst !== 1'b1 || d_rdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got %h vld=%b fst=%b rdy=%b want 11000000 1 1 0",
                         i, q, q_vld, q_fst, d_rdy);
            end
            @(negedge clk);
        end
        q_rdy = 1'b1;
        #1;
        checks++;
        if (d_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_rdy: got %b want 1", d_rdy);
        end
        @(negedge clk);
        checks++;
        if (q !== 32'h12000000 || q_vld !== 1'b1 || q_fst !== 1'b0) begin
            errors++;
            $display("FAIL bp_reload: got %h vld=%b fst=%b want 12000000 1 0", q, q_vld, q_fst);
        end
        d_in = 32'h13000000;
        @(negedge clk);
        checks++;
        if (q !== 32'h13000000 || q_vld !== 1'b1) begin
            errors++;
            $display("FAIL bp_next: got %h vld=%b want 13000000 1", q, q_vld);
        end
        d_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (q_vld !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got vld=%b want 0", q_vld);
        end
    endtask

    task automatic test_mask_gating();
        logic [5:0] mask_exp;
        mask_exp = 6'b110101; // element i at bit i: +,-,+,-,+,+
        err_en = 1'b1;
        q_rdy  = 1'b1;
        eo_rdy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            d_in  = mask_exp[i] ? 32'h3F800000 : 32'hBF800000;
            d_fst = (i == 0);
            d_vld = 1'b1;
            if (i == 5) begin
                e_in  = 32'h3F800000;
                e_fst = 1'b1;
                e_vld = 1'b1;
            end
            #1;
            checks++;
            if (d_rdy !== 1'b1) begin
                errors++;
                $display("FAIL mask_fill_rdy%0d: got %b want 1", i, d_rdy);
            end
            if (i == 5) begin
                checks++;
                if (e_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL mask_err_blocked: got e_rdy=%b want 0", e_rdy);
                end
            end
            @(negedge clk);
        end
        d_vld = 1'b0;
        d_fst = 1'b0;
        #1;
        checks++;
        if (d_rdy !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mask_hold: got rdy=%b busy=%b want rdy=0 busy=1", d_rdy, busy);
        end
        for (int j = 0; j < 6; j++) begin
            e_in  = 32'h3F800000;
            e_fst = (j == 0);
            e_vld = 1'b1;
            #1;
            checks++;
            if (e_rdy !== 1'b1) begin
                errors++;
                $display("FAIL mask_err_rdy%0d: got %b want 1", j, e_rdy);
            end
            @(negedge clk);
            checks++;
            if (eo !== (mask_exp[j] ? 32'h3F800000 : 32'h0) || eo_vld !== 1'b1
                || eo_fst !== (j == 0)) begin
                errors++;
                $display("FAIL mask_err%0d: got %h vld=%b fst=%b want %h vld=1 fst=%b", j, eo,
                         eo_vld, eo_fst, (mask_exp[j] ? 32'h3F800000 : 32'h0), (j == 0));
            end
        end
        e_vld = 1'b0;
        e_fst = 1'b0;
        #1;
        checks++;
        if (d_rdy !== 1'b1 || busy !== 1'b0 || e_rdy !== 1'b0) begin
            errors++;
            $display("FAIL mask_back_to_fill: got rdy=%b busy=%b e_rdy=%b want 1 0 0",
                     d_rdy, busy, e_rdy);
        end
        @(negedge clk);
        checks++;
        if (eo_vld !== 1'b0) begin
            errors++;
            $display("FAIL mask_err_drain: got vld=%b want 0", eo_vld);
        end
    endtask

    task automatic test_fst_restart();
        err_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            d_in  = 32'h40000000;
            d_fst = (k == 0) || (k == 3);
            d_vld = 1'b1;
            #1;
            checks++;
            if (d_rdy !== 1'b1) begin
                errors++;
                $display("FAIL fst_rdy%0d: got %b want 1", k, d_rdy);
            end
            @(negedge clk);
            checks++;
            if (busy !== (k == 8)) begin
                errors++;
                $display("FAIL fst_busy%0d: got %b want %b", k, busy, (k == 8));
            end
        end
        d_vld  = 1'b0;
        d_fst  = 1'b0;
        err_en = 1'b0;
        #1;
        checks++;
        if (e_rdy !== 1'b0 || d_rdy !== 1'b1) begin
            errors++;
            $display("FAIL fst_inference_gate: got e_rdy=%b d_rdy=%b want 0 1", e_rdy, d_rdy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fst_err_en_exit: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_in_hold();
        err_en = 1'b1;
        eo_rdy = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            d_in  = 32'h3F800000;
            d_fst = (i == 0);
            d_vld = 1'b1;
            @(negedge clk);
        end
        d_vld = 1'b0;
        d_fst = 1'b0;
        e_in  = 32'h3F800000;
        e_fst = 1'b1;
        e_vld = 1'b1;
        @(negedge clk);
        checks++;
        if (eo_vld !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: got eo_vld=%b busy=%b want 1 1", eo_vld, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (eo_vld !== 1'b0 || q_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got eo_vld=%b q_vld=%b busy=%b want 0 0 0",
                     eo_vld, q_vld, busy);
        end
        e_vld  = 1'b0;
        e_fst  = 1'b0;
        eo_rdy = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (d_rdy !== 1'b1 || busy !== 1'b0 || e_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart: got rdy=%b busy=%b e_rdy=%b want 1 0 0",
                     d_rdy, busy, e_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_relu_stream();
        test_leaky();
        test_leaky_error();
        test_backpressure();
        test_mask_gating();
        test_fst_restart();
        test_reset_in_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
